// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use, branch flush,
// mul/div EX occupancy and MEM wait states. Optional perf counter: HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_RegisterRt,
  input  logic [4:0]  IF_ID_RegisterRs,
  input  logic [4:0]  IF_ID_RegisterRt,
  input  logic        Branch_Taken,
  input  logic        MulDiv_Start,
  input  logic        Mem_Stall,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Write,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Write,
  output logic        EX_MEM_Flush,
  output logic        MEM_WB_Flush,
  output logic        MulDiv_Busy,
  output logic [31:0] Stall_Cycles
);

  typedef enum logic [1:0] {RUN, MULDIV, MD_DONE, MEMWAIT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               load_use;

  assign load_use = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                    ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                     (ID_EX_RegisterRt == IF_ID_RegisterRt));

  always_comb begin
    // NOTE: every output and next-state signal gets a default first, so no
    // path through the branches below can leave one unassigned (no latches).
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    EX_MEM_Write = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    MEM_WB_Flush = 1'b0;
    MulDiv_Busy  = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;

    if (rst_i) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
      MEM_WB_Flush = 1'b1;
      state_d      = RUN;
      cnt_d        = '0;
    end else if (Mem_Stall) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Flush = 1'b1;
      if (state_q == MULDIV) begin
        // The mul/div keeps running underneath the memory wait.
        cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
      end else begin
        state_d = MEMWAIT;
      end
    end else if (state_q == MULDIV && cnt_q != '0) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Flush = 1'b1;
      MulDiv_Busy  = 1'b1;
      cnt_d        = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) state_d = MD_DONE;
    end else if (state_q == RUN && MulDiv_Start) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Flush = 1'b1;
      MulDiv_Busy  = 1'b1;
      cnt_d        = CNT_W'(MULDIV_CYCLES - 2);
      state_d      = (MULDIV_CYCLES > 2) ? MULDIV : MD_DONE;
    end else begin
      // RUN, MD_DONE, a released MEMWAIT, or a MULDIV whose count expired
      // during a memory wait (that cycle acts as its MD_DONE).
      state_d = RUN;
      if (load_use) begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
      end else if (Branch_Taken) begin
        IF_ID_Flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (!PC_Write && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign Stall_Cycles = stall_cnt_q;
`else
  assign Stall_Cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (MULDIV_CYCLES=4) with an expected-vector queue.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt;
  logic        Branch_Taken, MulDiv_Start, Mem_Stall;
  logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush;
  logic        EX_MEM_Write, EX_MEM_Flush, MEM_WB_Flush, MulDiv_Busy;
  logic [31:0] Stall_Cycles;

  typedef struct {
    logic [8:0] v;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Bit order: PC_W, IFID_W, IFID_F, IDEX_W, IDEX_F, EXMEM_W, EXMEM_F, MEMWB_F, BUSY
  localparam logic [8:0] NORM = 9'b1_1_0_1_0_1_0_0_0;
  localparam logic [8:0] RST  = 9'b0_0_1_0_1_0_1_1_0;
  localparam logic [8:0] MEM  = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] MD   = 9'b0_0_0_0_0_1_1_0_1;
  localparam logic [8:0] LU   = 9'b0_0_0_1_1_1_0_0_0;
  localparam logic [8:0] BR   = 9'b1_1_1_1_0_1_0_0_0;

  hazard_stall_ctrl #(.MULDIV_CYCLES(4), .CNT_W(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .ID_EX_MemRead   (ID_EX_MemRead),
    .ID_EX_RegisterRt(ID_EX_RegisterRt),
    .IF_ID_RegisterRs(IF_ID_RegisterRs),
    .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .Branch_Taken    (Branch_Taken),
    .MulDiv_Start    (MulDiv_Start),
    .Mem_Stall       (Mem_Stall),
    .PC_Write        (PC_Write),
    .IF_ID_Write     (IF_ID_Write),
    .IF_ID_Flush     (IF_ID_Flush),
    .ID_EX_Write     (ID_EX_Write),
    .ID_EX_Flush     (ID_EX_Flush),
    .EX_MEM_Write    (EX_MEM_Write),
    .EX_MEM_Flush    (EX_MEM_Flush),
    .MEM_WB_Flush    (MEM_WB_Flush),
    .MulDiv_Busy     (MulDiv_Busy),
    .Stall_Cycles    (Stall_Cycles)
  );

  always #5 clk = ~clk;

  // Inputs are set at a falling edge; this pushes the expectation, samples
  // 1 ns later, then advances to the next falling edge.
  task automatic cyc(input logic [8:0] exp_v, input string tag);
    exp_t e, got;
    logic [8:0] obs;
    e.v = exp_v;
    e.tag = tag;
    exp_q.push_back(e);
    #1;
    obs = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
           EX_MEM_Write, EX_MEM_Flush, MEM_WB_Flush, MulDiv_Busy};
    got = exp_q.pop_front();
    vectors++;
    assert (obs === got.v) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", got.tag, obs, got.v);
    end
    @(negedge clk);
  endtask

  task automatic check_sc(input logic [31:0] exp_sc, input string tag);
    vectors++;
    assert (Stall_Cycles === exp_sc) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, Stall_Cycles, exp_sc);
    end
  endtask

  initial begin
    logic [31:0] perf_exp;
`ifdef HAZARD_PERF_CNT_EN
    perf_exp = 32'd3;
`else
    perf_exp = 32'd0;
`endif
    rst_i = 1'b1; ID_EX_MemRead = 1'b0; ID_EX_RegisterRt = 5'd0;
    IF_ID_RegisterRs = 5'd0; IF_ID_RegisterRt = 5'd0;
    Branch_Taken = 1'b0; MulDiv_Start = 1'b0; Mem_Stall = 1'b0;

    cyc(RST, "reset0");
    cyc(RST, "reset1");
    #1 check_sc(32'd0, "perf_after_reset");
    rst_i = 1'b0;
    cyc(NORM, "idle");

    // Load-use via Rs, then released; $zero never stalls; match via Rt.
    ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd8; IF_ID_RegisterRs = 5'd8;
    cyc(LU, "lu_rs");
    ID_EX_MemRead = 1'b0;
    cyc(NORM, "lu_one_cycle");
    ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd0; IF_ID_RegisterRs = 5'd0;
    cyc(NORM, "lu_r0");
    ID_EX_RegisterRt = 5'd5; IF_ID_RegisterRs = 5'd3; IF_ID_RegisterRt = 5'd5;
    cyc(LU, "lu_rt");

    // Branch with load-use is suppressed; branch alone flushes IF/ID.
    Branch_Taken = 1'b1;
    cyc(LU, "br_with_lu");
    ID_EX_MemRead = 1'b0;
    cyc(BR, "br_alone");
    Branch_Taken = 1'b0;
    cyc(NORM, "br_done");

    // Mul/div: 3 stall cycles, then MD_DONE ignoring a new start pulse.
    MulDiv_Start = 1'b1;
    cyc(MD, "md_t0");
    MulDiv_Start = 1'b0;
    cyc(MD, "md_t1");
    cyc(MD, "md_t2");
    MulDiv_Start = 1'b1;
    cyc(NORM, "md_done_ignores_start");
    MulDiv_Start = 1'b0;
    cyc(NORM, "md_after");

    // Memory wait for 5 cycles.
    Mem_Stall = 1'b1;
    for (int i = 0; i < 5; i++) cyc(MEM, "memwait");
    Mem_Stall = 1'b0;
    cyc(NORM, "memwait_release");

    // Memory wait overlapping a mul/div: MD_DONE lands on the release cycle.
    MulDiv_Start = 1'b1;
    cyc(MD, "mdmem_t0");
    MulDiv_Start = 1'b0; Mem_Stall = 1'b1;
    for (int i = 0; i < 6; i++) cyc(MEM, "mdmem_hold");
    Mem_Stall = 1'b0;
    cyc(NORM, "mdmem_done");
    cyc(NORM, "mdmem_no_extra");

    // Reset in the middle of a mul/div.
    MulDiv_Start = 1'b1;
    cyc(MD, "mdrst_t0");
    MulDiv_Start = 1'b0; rst_i = 1'b1;
    cyc(RST, "mdrst_reset");
    #1 check_sc(32'd0, "perf_cleared");
    rst_i = 1'b0;
    cyc(NORM, "mdrst_run0");
    cyc(NORM, "mdrst_run1");

    // Performance counter after one full mul/div.
    MulDiv_Start = 1'b1;
    cyc(MD, "perf_md0");
    MulDiv_Start = 1'b0;
    cyc(MD, "perf_md1");
    cyc(MD, "perf_md2");
    cyc(NORM, "perf_md_done");
    #1 check_sc(perf_exp, "perf_count");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline stall/flush sequencer for the 5-stage MIPS core. It sits beside the forwarding unit and owns every pipeline-register write-enable and flush. It handles four hazard sources:
- load-use hazards
- taken-branch flush in ID
- multi-cycle mul/div occupancy of EX
- data-memory wait states in MEM

Parameters:
MULDIV_CYCLES, 4, total cycles a mul/div occupies EX (legal range 2..15)
CNT_W, 4, width of the mul/div down-counter

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous, active-high reset
ID_EX_MemRead  in  1  instruction in EX is a load
ID_EX_RegisterRt  in  5  load destination register
IF_ID_RegisterRs  in  5  source Rs of the instruction in ID
IF_ID_RegisterRt  in  5  source Rt of the instruction in ID
Branch_Taken  in  1  branch resolved taken in ID this cycle
MulDiv_Start  in  1  one-cycle pulse: a mul/div has entered EX
Mem_Stall  in  1  level; MEM stage is waiting on data memory
PC_Write  out  1  PC update enable
IF_ID_Write  out  1  IF/ID register enable
IF_ID_Flush  out  1  load a NOP into IF/ID
ID_EX_Write  out  1  ID/EX register enable
ID_EX_Flush  out  1  load a bubble into ID/EX
EX_MEM_Write  out  1  EX/MEM register enable
EX_MEM_Flush  out  1  load a bubble into EX/MEM
MEM_WB_Flush  out  1  load a bubble into MEM/WB
MulDiv_Busy  out  1  the mul/div unit is holding EX
Stall_Cycles  out  32  performance counter; see Optional Feature

Behaviour:
- States: RUN, MULDIV, MD_DONE, MEMWAIT.
- Outputs are combinational from state and inputs.
- Defaults: all *_Write=1, all *_Flush=0, MulDiv_Busy=0.
- While rst_i=1:
  - all *_Write=0, all *_Flush=1, MulDiv_Busy=0
  - next state RUN, counter=0, Stall_Cycles=0
- Priority in every state, highest first:
  1. Mem_Stall
  2. mul/div stall
  3. load-use
  4. branch flush
- Mem_Stall=1, any state:
  - PC_Write=IF_ID_Write=ID_EX_Write=EX_MEM_Write=0
  - MEM_WB_Flush=1
  - all other flushes 0
- Mem_Stall transitions:
  - From RUN or MD_DONE: go to MEMWAIT.
  - In MEMWAIT: stay while Mem_Stall=1; go to RUN on the first cycle Mem_Stall=0. That cycle uses normal RUN evaluation.
  - In MULDIV: the counter keeps decrementing but saturates at 0. The MULDIV->MD_DONE exit is blocked until Mem_Stall=0.
- RUN, MulDiv_Start=1 (and Mem_Stall=0):
  - PC_Write=IF_ID_Write=ID_EX_Write=0
  - EX_MEM_Flush=1, MulDiv_Busy=1
  - Load counter with MULDIV_CYCLES-2.
  - Next state: MULDIV if MULDIV_CYCLES>2, else MD_DONE.
- MULDIV:
  - Same outputs as the start cycle.
  - Counter decrements each cycle.
  - When counter==1 and Mem_Stall=0, go to MD_DONE (or when counter is 0, after a Mem_Stall hold).
  - Net effect: stalled cycles = MULDIV_CYCLES-1, counting the start cycle.
- MD_DONE:
  - One cycle with no mul/div stall; the mul/div result advances to MEM.
  - MulDiv_Start is ignored.
  - Load-use and branch rules apply.
  - Next state RUN, or MEMWAIT if Mem_Stall=1.
- Load-use, in RUN or MD_DONE, with no higher-priority event:
  - Condition: ID_EX_MemRead && ID_EX_RegisterRt!=0 && (ID_EX_RegisterRt==IF_ID_RegisterRs || ID_EX_RegisterRt==IF_ID_RegisterRt).
  - Response: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 for exactly that cycle.
  - No state change.
- Branch_Taken with no higher-priority event: IF_ID_Flush=1 for that cycle.
  - When Branch_Taken coincides with load-use, the branch is suppressed; ID re-resolves it next cycle.
- MulDiv_Start arriving in MULDIV or MEMWAIT is a protocol error and is ignored.
- Reset asserted mid-MULDIV: next state RUN, counter cleared, no further stall.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Stall_Cycles increments by 1 on every non-reset cycle with PC_Write=0.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by rst_i.
- Undefined: Stall_Cycles is tied to 32'd0 and no counter register is built.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_RegisterRt=8, IF_ID_RegisterRs=8 -> for exactly 1 cycle PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Repeat with Rt=0 -> no stall.
- MULDIV_CYCLES=4, MulDiv_Start pulse at cycle T -> PC_Write=0 and MulDiv_Busy=1 at T, T+1, T+2; EX_MEM_Flush=1 on the same cycles; MD_DONE at T+3 with all Write=1.
- Mem_Stall high for cycles T..T+4 -> all Write=0 and MEM_WB_Flush=1 for 5 cycles; normal outputs at T+5.
- Mem_Stall raised at T+1 during a MULDIV_CYCLES=4 sequence and held for 6 cycles -> MD_DONE delayed until the first cycle Mem_Stall=0; no extra mul/div stall after it.
- Branch_Taken together with load-use -> IF_ID_Flush=0 and the load-use stall is applied. Branch_Taken alone -> IF_ID_Flush=1 for 1 cycle.
- rst_i at T+1 of a mul/div sequence, then released -> all Write=0 and all Flush=1 during reset; RUN defaults on the next cycle. With HAZARD_PERF_CNT_EN defined: Stall_Cycles=0 after reset, and reads 3 after a subsequent MULDIV_CYCLES=4 run.
